half_duplex_responder: RTL and testbench



---
 rtl/half_duplex_pkg.sv | 7 +
 rtl/hd_turn_timer.sv | 18 +
 rtl/half_duplex_responder.sv | 115 +++++++++++
 tb/tb_half_duplex_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/half_duplex_pkg.sv
// half_duplex_pkg: state encoding and counter sizing shared by the half-duplex responder.
package half_duplex_pkg;
  typedef enum logic [2:0] {IDLE, RX_HOLD, WAIT_TX, TURN, DRIVE} hd_state_e;
  function automatic int cnt_w(input int turn_cyc, input int timeout_cyc);
    return $clog2((turn_cyc > timeout_cyc ? turn_cyc : timeout_cyc) + 1);
  endfunction
endpackage

// File: rtl/hd_turn_timer.sv
// hd_turn_timer: clearable up-counter flagging when the count equals limit; shared by turnaround and reply timeout.
module hd_turn_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign done = cnt_q == limit;
endmodule

// File: rtl/half_duplex_responder.sv
// half_duplex_responder: responder end of a shared half-duplex word bus (capture, reply, turnaround, drive).
// Define HD_RESP_READBACK_CHECK_EN to add err_readback, comparing the bus against our drive in DRIVE.
module half_duplex_responder
  import half_duplex_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TURN_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pad_i,
  input  logic              init_strb,
  output logic [DATA_W-1:0] pad_o,
  output logic              pad_oe,
  output logic              resp_strb,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              err_timeout,
  output logic              err_collide
`ifdef HD_RESP_READBACK_CHECK_EN
  ,
  output logic              err_readback
`endif
);
  localparam int CNT_W = cnt_w(TURN_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] TIME_LIM = CNT_W'(TIMEOUT_CYC - 1);
  hd_state_e         state_q;
  logic              init_q, pad_oe_q, resp_q, rx_valid_q, tx_ready_q, err_to_q, err_col_q;
  logic [DATA_W-1:0] pad_o_q, rx_data_q;
  logic              tmr_clear, tmr_en, tmr_done;
  always_comb begin
    tmr_en    = state_q == WAIT_TX || state_q == TURN;
    tmr_clear = !tmr_en || (state_q == TURN && init_strb) || (state_q == WAIT_TX && tx_valid);
  end
  hd_turn_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (state_q == TURN ? TURN_LIM : TIME_LIM),
    .done   (tmr_done)
  );
`ifdef HD_RESP_READBACK_CHECK_EN
  logic err_rb_q;
  always_ff @(posedge clk or posedge rst)
    if (rst)                                      err_rb_q <= 1'b0;
    else if (state_q == DRIVE && pad_i != pad_o_q) err_rb_q <= 1'b1;
  assign err_readback = err_rb_q;
`endif
  // init_q resets high so a strobe already asserted out of reset is not seen as a new request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      init_q     <= 1'b1;
      pad_oe_q   <= 1'b0;
      resp_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_col_q  <= 1'b0;
      pad_o_q    <= '0;
      rx_data_q  <= '0;
    end else begin
      init_q <= init_strb;
      case (state_q)
        IDLE: if (init_strb && !init_q) begin
          rx_data_q  <= pad_i;
          rx_valid_q <= 1'b1;
          state_q    <= RX_HOLD;
        end
        RX_HOLD: if (rx_ready) begin
          rx_valid_q <= 1'b0;
          tx_ready_q <= 1'b1;
          state_q    <= WAIT_TX;
        end
        WAIT_TX: if (tx_valid) begin
          pad_o_q    <= tx_data;
          tx_ready_q <= 1'b0;
          state_q    <= TURN;
        end else if (tmr_done) begin
          err_to_q   <= 1'b1;
          tx_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
        TURN: if (!init_strb && tmr_done) begin
          pad_oe_q <= 1'b1;
          resp_q   <= 1'b1;
          state_q  <= DRIVE;
        end
        DRIVE: begin
          pad_oe_q <= 1'b0;
          resp_q   <= 1'b0;
          pad_o_q  <= '0;
          state_q  <= IDLE;
          if (init_strb) err_col_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pad_o       = pad_o_q;
  assign pad_oe      = pad_oe_q;
  assign resp_strb   = resp_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign err_timeout = err_to_q;
  assign err_collide = err_col_q;
endmodule

// File: tb/tb_half_duplex_responder.sv
// tb_half_duplex_responder: directed and randomized transactions checked against transaction-level expectations.
module tb_half_duplex_responder;
  localparam int DW = 8, TC = 2, TO = 255;
  logic          clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] pad_i = '0, tx_data = '0;
  logic          init_strb = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
  logic [DW-1:0] pad_o, rx_data;
  logic          pad_oe, resp_strb, rx_valid, tx_ready, err_timeout, err_collide;
  int            checks = 0, errors = 0;
  bit            exp_to = 1'b0, exp_col = 1'b0, exp_rb = 1'b0;
`ifdef HD_RESP_READBACK_CHECK_EN
  logic          err_readback;
`endif
  always #5 clk = ~clk;
  half_duplex_responder #(.DATA_W(DW), .TURN_CYC(TC), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .pad_i       (pad_i),
    .init_strb   (init_strb),
    .pad_o       (pad_o),
    .pad_oe      (pad_oe),
    .resp_strb   (resp_strb),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .err_timeout (err_timeout),
    .err_collide (err_collide)
`ifdef HD_RESP_READBACK_CHECK_EN
    ,
    .err_readback(err_readback)
`endif
  );
  task automatic step;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Request phase: one low sample, rising strobe with req on the bus, then accept after rx_wait cycles.
  task automatic front(input logic [7:0] req, input int rx_wait);
    init_strb = 1'b0;
    step;
    init_strb = 1'b1;
    pad_i     = req;
    rx_ready  = 1'b0;
    step;
    for (int i = 0; i < rx_wait; i++) begin
      chk("rx_valid_hold", rx_valid, 1);
      step;
    end
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, req);
    rx_ready = 1'b1;
    pad_i    = 8'($urandom);
    step;
    rx_ready = 1'b0;
    chk("rx_clear", rx_valid, 0);
    chk("tx_ready", tx_ready, 1);
  endtask
  // Full transaction: drive must appear after hi high samples plus TC low samples following the reply handshake.
  task automatic xact(input logic [7:0] req, input logic [7:0] rsp, input int rx_wait, input int tx_wait,
                      input int hi, input bit collide, input bit rst_drive);
    front(req, rx_wait);
    for (int i = 0; i < tx_wait; i++) begin
      init_strb = 1'($urandom);
      step;
      chk("tx_wait_ready", tx_ready, 1);
      chk("no_recapture", rx_valid, 0);
    end
    tx_valid = 1'b1;
    tx_data  = rsp;
    step;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int j = 0; j < hi + TC; j++) begin
      chk("turn_oe", pad_oe, 0);
      chk("turn_ready", tx_ready, 0);
      init_strb = (j < hi);
      step;
    end
    chk("drive_oe", pad_oe, 1);
    chk("drive_data", pad_o, rsp);
    chk("drive_strb", resp_strb, 1);
    chk("rx_data_kept", rx_data, req);
    init_strb = collide;
    pad_i     = collide ? 8'h00 : rsp;
`ifdef HD_RESP_READBACK_CHECK_EN
    if (collide && rsp != 8'h00) exp_rb = 1'b1;
`endif
    if (rst_drive) begin
      rst = 1'b1;
      #1;
      chk("rst_oe", pad_oe, 0);
      chk("rst_err_collide", err_collide, 0);
      chk("rst_err_timeout", err_timeout, 0);
      exp_to  = 1'b0;
      exp_col = 1'b0;
      exp_rb  = 1'b0;
      step;
      rst       = 1'b0;
      init_strb = 1'b0;
      return;
    end
    exp_col |= collide;
    step;
    chk("release_oe", pad_oe, 0);
    chk("release_strb", resp_strb, 0);
    chk("release_data", pad_o, 0);
    chk("err_collide", err_collide, exp_col);
    chk("err_timeout", err_timeout, exp_to);
`ifdef HD_RESP_READBACK_CHECK_EN
    chk("err_readback", err_readback, exp_rb);
`endif
    init_strb = 1'b0;
  endtask
  task automatic timeout_run(input logic [7:0] req);
    front(req, 0);
    init_strb = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_ready", tx_ready, 1);
      chk("to_oe", pad_oe, 0);
      chk("to_flag", err_timeout, exp_to);
      step;
    end
    exp_to = 1'b1;
    chk("to_ready_drop", tx_ready, 0);
    chk("err_timeout_set", err_timeout, 1);
    chk("to_oe_after", pad_oe, 0);
    step;
    chk("to_idle_rx", rx_valid, 0);
    chk("to_idle_oe", pad_oe, 0);
  endtask
  initial begin
    #1;
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_pad_o", pad_o, 0);
    chk("rst_resp_strb", resp_strb, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_collide", err_collide, 0);
    init_strb = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("level_ignored", rx_valid, 0);
    end
    xact(8'hA5, 8'h3C, 0, 0, 0, 1'b0, 1'b0);
    xact(8'h5A, 8'hC3, 1, 2, 5, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++)
      xact(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 4)), 1'b0, 1'b0);
    timeout_run(8'h77);
    xact(8'h11, 8'h3C, 0, 0, 0, 1'b1, 1'b0);
    xact(8'h22, 8'h3C, 0, 1, 0, 1'b0, 1'b1);
    xact(8'($urandom), 8'($urandom), 2, 1, 1, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
